// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into word-aligned data_memory accesses.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of splitting them.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          WORD_ADDR  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rd0_q, rd0_d;
  logic [31:0]             rd1_q, rd1_d;
  logic                    err_q, err_d;

  // Byte-lane mask over the two-word window starting at the aligned word.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0f;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] to_mem_addr(input logic [ADDR_WIDTH-1:0] b);
    return WORD_ADDR ? (b >> 2) : b;
  endfunction

  logic req_illegal, req_trap;

  always_comb begin
    req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [7:0] req_mask;
  always_comb begin
    req_mask = lane_mask(req_funct3[1:0], req_addr[1:0]);
    req_trap = |req_mask[7:4];
  end
`else
  assign req_trap = 1'b0;
`endif

  logic [7:0]            mask;
  logic                  split;
  logic [4:0]            sh_amt;
  logic [63:0]           d64;
  logic [31:0]           ld_raw, ld_ext;
  logic [ADDR_WIDTH-1:0] word0, word1;

  always_comb begin
    mask   = lane_mask(f3_q[1:0], addr_q[1:0]);
    split  = |mask[7:4];
    sh_amt = {addr_q[1:0], 3'b000};
    d64    = {32'h0, wdata_q} << sh_amt;
    // Bytes past the access size are truncated, so a stale rd1_q never leaks through.
    ld_raw = 32'({rd1_q, rd0_q} >> sh_amt);
    word0  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    word1  = word0 + ADDR_WIDTH'(4);
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'b100:  ld_ext = {24'h0, ld_raw[7:0]};
      3'b101:  ld_ext = {16'h0, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    mem_addr  = '0;
    mem_we    = 4'h0;
    mem_wdata = 32'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_illegal || req_trap;
          state_d = (req_illegal || req_trap) ? StResp : StAcc0;
        end
      end
      StAcc0: begin
        mem_addr = to_mem_addr(word0);
        if (we_q) begin
          mem_we    = mask[3:0];
          mem_wdata = d64[31:0] & lane_bits(mask[3:0]);
        end
        rd0_d   = mem_rdata;
        state_d = split ? StAcc1 : StResp;
      end
      StAcc1: begin
        mem_addr = to_mem_addr(word1);
        if (we_q) begin
          mem_we    = mask[7:4];
          mem_wdata = d64[63:32] & lane_bits(mask[7:4]);
        end
        rd1_d   = mem_rdata;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? 32'h0 : ld_ext;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      err_q   <= err_d;
    end
  end

endmodule
